// File: rtl/game_ctrl.sv
// Game sequencer: collision detection, obstacle control, score and high score.
// Optional HIT_DEBOUNCE_EN: require overlap on two consecutive strobes before HIT.
module game_ctrl #(
    parameter int N_OBS        = 2,
    parameter int GRACE_FRAMES = 120,
    parameter int HIT_FRAMES   = 30,
    parameter int SCORE_DIV    = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_start,
    input  logic [47:0]          i_dino_box,
    input  logic [48*N_OBS-1:0]  i_obs_box,
    output logic                 o_obs_rst,
    output logic                 o_animate,
    output logic                 o_grace,
    output logic                 o_game_over,
    output logic [15:0]          o_score,
    output logic [15:0]          o_hiscore,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        GRACE = 3'd2,
        RUN   = 3'd3,
        HIT   = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam int FRAME_MAX = (GRACE_FRAMES > HIT_FRAMES) ? GRACE_FRAMES : HIT_FRAMES;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int DW        = (SCORE_DIV > 1) ? $clog2(SCORE_DIV + 1) : 1;

    state_t          state_q, state_d;
    logic            start_prev_q, start_prev_d;
    logic [FW-1:0]   frame_q, frame_d, frame_inc;
    logic [DW-1:0]   div_q, div_d, div_inc;
    logic [15:0]     score_q, score_d;
    logic [15:0]     hiscore_q, hiscore_d;
    logic            start_ev;
    logic            any_ovl;
    logic            hit_now;

    // Dino x is zero-extended so it compares correctly against signed obstacle x.
    logic signed [12:0] dx1_s, dx2_s;
    logic        [11:0] dy1, dy2;
    logic [N_OBS-1:0]   ovl;

    assign dx1_s = {1'b0, i_dino_box[47:36]};
    assign dx2_s = {1'b0, i_dino_box[35:24]};
    assign dy1   = i_dino_box[23:12];
    assign dy2   = i_dino_box[11:0];

    for (genvar k = 0; k < N_OBS; k++) begin : g_obs
        logic        [47:0] box;
        logic signed [12:0] ox1_s, ox2_s;
        assign box    = i_obs_box[48*k +: 48];
        assign ox1_s  = {box[47], box[47:36]};
        assign ox2_s  = {box[35], box[35:24]};
        assign ovl[k] = (dx1_s < ox2_s) && (ox1_s < dx2_s) &&
                        (dy1 < box[11:0]) && (box[23:12] < dy2);
    end

    assign any_ovl  = |ovl;
    assign start_ev = i_start && !start_prev_q;

`ifdef HIT_DEBOUNCE_EN
    logic pend_q, pend_d;
    assign hit_now = any_ovl && pend_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pend_q <= 1'b0;
        else          pend_q <= pend_d;
    end
`else
    assign hit_now = any_ovl;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            frame_q      <= '0;
            div_q        <= '0;
            score_q      <= '0;
            hiscore_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            frame_q      <= frame_d;
            div_q        <= div_d;
            score_q      <= score_d;
            hiscore_q    <= hiscore_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_prev_d = i_start;
        frame_d      = frame_q;
        div_d        = div_q;
        score_d      = score_q;
        hiscore_d    = hiscore_q;
        frame_inc    = frame_q + FW'(1);
        div_inc      = div_q + DW'(1);
`ifdef HIT_DEBOUNCE_EN
        pend_d       = pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_ev) state_d = CLR;
            end
            CLR: begin
                score_d = '0;
                frame_d = '0;
                div_d   = '0;
`ifdef HIT_DEBOUNCE_EN
                pend_d  = 1'b0;
`endif
                state_d = GRACE;
            end
            GRACE: begin
                if (i_ani_stb) begin
                    if (frame_inc == FW'(GRACE_FRAMES)) begin
                        frame_d = '0;
                        state_d = RUN;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
            end
            RUN: begin
                if (i_ani_stb) begin
`ifdef HIT_DEBOUNCE_EN
                    pend_d = any_ovl;
`endif
                    if (hit_now) begin
                        frame_d = '0;
                        state_d = HIT;
                    end else if (div_inc == DW'(SCORE_DIV)) begin
                        div_d = '0;
                        if (score_q != '1) score_d = score_q + 16'd1;
                    end else begin
                        div_d = div_inc;
                    end
                end
            end
            HIT: begin
                if (i_ani_stb) begin
                    if (frame_inc == FW'(HIT_FRAMES)) begin
                        frame_d = '0;
                        state_d = OVER;
                        if (score_q > hiscore_q) hiscore_d = score_q;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
            end
            OVER: begin
                if (start_ev) state_d = CLR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_obs_rst   = (state_q == CLR);
    assign o_animate   = (state_q == GRACE) || (state_q == RUN);
    assign o_grace     = (state_q == GRACE);
    assign o_game_over = (state_q == OVER);
    assign o_score     = score_q;
    assign o_hiscore   = hiscore_q;
    assign o_state     = state_q;

endmodule
